// File: rtl/rail_enable_sequencer.sv
// rail_enable_sequencer: five-rail PMIC enable sequencer with ordered power-up, reverse power-down and all-off fault.
// Define RAIL_SEQ_PG_SYNC_EN to pass i_pg through a two-flop synchronizer before use.
module rail_enable_sequencer #(
    parameter logic [31:0] STEP_DELAY = 32'd1000,
    parameter logic [31:0] PG_TIMEOUT = 32'd100000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic [4:0] i_pg,
    output logic [4:0] o_en,
    output logic       o_powered,
    output logic       o_busy,
    output logic       o_fault,
    output logic [2:0] o_fault_rail
);
    typedef enum logic [2:0] {S_OFF, S_RAMP_UP, S_SETTLE, S_ON, S_RAMP_DOWN, S_FAULT} state_t;
    state_t      state_q, state_d;
    logic [2:0]  k_q, k_d, fault_rail_q, fault_rail_d, bad_idx, top_idx;
    logic [31:0] cnt_q, cnt_d;
    logic [4:0]  en_q, en_d, pg, bad;
    logic        powered_q, busy_q, fault_q;
`ifdef RAIL_SEQ_PG_SYNC_EN
    logic [4:0] pg_meta_q, pg_sync_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pg_meta_q <= '0;
            pg_sync_q <= '0;
        end else begin
            pg_meta_q <= i_pg;
            pg_sync_q <= pg_meta_q;
        end
    end
    assign pg = pg_sync_q;
`else
    assign pg = i_pg;
`endif
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        cnt_d        = cnt_q;
        en_d         = en_q;
        fault_rail_d = fault_rail_q;
        bad          = en_q & ~pg;
        bad_idx      = '0;
        top_idx      = '0;
        // The rail still waiting for power-good is judged by the timeout, not here.
        if (state_q == S_RAMP_UP) bad[k_q] = 1'b0;
        for (int i = 4; i >= 0; i--) if (bad[i]) bad_idx = i[2:0];
        for (int i = 0; i < 5; i++) if (en_q[i]) top_idx = i[2:0];
        if ((state_q inside {S_RAMP_UP, S_SETTLE, S_ON}) && |bad) begin
            state_d      = S_FAULT;
            en_d         = '0;
            cnt_d        = '0;
            fault_rail_d = bad_idx;
        end else begin
            case (state_q)
                S_OFF: begin
                    en_d = '0;
                    if (i_enable) begin
                        state_d = S_RAMP_UP;
                        k_d     = '0;
                        en_d    = 5'b00001;
                        cnt_d   = '0;
                    end
                end
                S_RAMP_UP: begin
                    if (!pg[k_q] && (cnt_q + 32'd1) >= PG_TIMEOUT) begin
                        state_d      = S_FAULT;
                        en_d         = '0;
                        cnt_d        = '0;
                        fault_rail_d = k_q;
                    end else if (!i_enable) begin
                        state_d       = S_RAMP_DOWN;
                        en_d[top_idx] = 1'b0;
                        cnt_d         = '0;
                    end else if (pg[k_q]) begin
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                S_SETTLE: begin
                    if (!i_enable) begin
                        state_d       = S_RAMP_DOWN;
                        en_d[top_idx] = 1'b0;
                        cnt_d         = '0;
                    end else if (k_q == 3'd4 && (cnt_q + 32'd1) >= STEP_DELAY) begin
                        state_d = S_ON;
                        cnt_d   = '0;
                    end else if (k_q != 3'd4 && cnt_q >= STEP_DELAY) begin
                        // Next rail is switched on the edge after the settle window closes.
                        state_d             = S_RAMP_UP;
                        k_d                 = k_q + 3'd1;
                        en_d[k_q + 3'd1]    = 1'b1;
                        cnt_d               = '0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                S_ON: begin
                    if (!i_enable) begin
                        state_d       = S_RAMP_DOWN;
                        en_d[top_idx] = 1'b0;
                        cnt_d         = '0;
                    end
                end
                S_RAMP_DOWN: begin
                    if (cnt_q >= STEP_DELAY) begin
                        cnt_d = '0;
                        if (en_q == '0) state_d = S_OFF;
                        else en_d[top_idx] = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                S_FAULT: begin
                    en_d = '0;
                    if (!i_enable) state_d = S_OFF;
                end
                default: begin
                    state_d = S_OFF;
                    en_d    = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_OFF;
            k_q          <= '0;
            cnt_q        <= '0;
            en_q         <= '0;
            fault_rail_q <= '0;
            powered_q    <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            cnt_q        <= cnt_d;
            en_q         <= en_d;
            fault_rail_q <= fault_rail_d;
            powered_q    <= state_d == S_ON;
            busy_q       <= state_d inside {S_RAMP_UP, S_SETTLE, S_RAMP_DOWN};
            fault_q      <= state_d == S_FAULT;
        end
    end
    assign o_en         = en_q;
    assign o_powered    = powered_q;
    assign o_busy       = busy_q;
    assign o_fault      = fault_q;
    assign o_fault_rail = fault_rail_q;
endmodule

// File: tb/tb_rail_enable_sequencer.sv
// tb_rail_enable_sequencer: randomized scenario bench for rail_enable_sequencer with STEP_DELAY=4, PG_TIMEOUT=10.
module tb_rail_enable_sequencer;
    localparam int S = 4;
    localparam int T = 10;
    logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
    logic [4:0] pg, en, pg_r = '0, kill = '0, stuck = '0;
    logic       powered, busy, fault;
    logic [2:0] frail;
    int         pg_dly[5], age[5], rise[5], pwr_at;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;
    assign pg = pg_r & ~kill;

    rail_enable_sequencer #(.STEP_DELAY(32'd4), .PG_TIMEOUT(32'd10)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_pg(pg),
        .o_en(en), .o_powered(powered), .o_busy(busy), .o_fault(fault), .o_fault_rail(frail)
    );

    // Regulator model: pg[k] is first sampled high pg_dly[k] edges after en[k] rises.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 5; k++) begin
            if (!en[k]) begin
                age[k] = 0;
                pg_r[k] = 1'b0;
            end else begin
                if (!stuck[k] && age[k] >= pg_dly[k] - 1) pg_r[k] = 1'b1;
                age[k]++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Power-up timeline from the ordering rules; r is the rail held without pg (5 = none).
    task automatic plan(input int r);
        stuck = '0;
        for (int k = 0; k < 5; k++) pg_dly[k] = $urandom_range(1, 8);
        if (r < 5) stuck[r] = 1'b1;
        rise[0] = 1;
        for (int k = 1; k < 5; k++) rise[k] = rise[k-1] + pg_dly[k-1] + S + 1;
        pwr_at = rise[4] + pg_dly[4] + S;
    endtask

    function automatic logic [4:0] exp_up(input int n, input int r);
        logic [4:0] e = '0;
        for (int k = 0; k < 5; k++) if (k <= r && n >= rise[k]) e[k] = 1'b1;
        if (r < 5 && n >= rise[r] + T) e = '0;
        return e;
    endfunction

    task automatic go_off;
        int i = 0;
        enable = 1'b0;
        while ((busy || en != 0 || fault) && i < 200) begin
            tick();
            i++;
        end
        checks++;
        if (i >= 200) begin
            errors++;
            $display("FAIL go_off timeout en=%b busy=%b fault=%b required idle", en, busy, fault);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        enable = 1'b0;
        #12;
        checks += 5;
        if (en !== 5'd0)   begin errors++; $display("FAIL reset en got %b exp 00000", en); end
        if (powered !== 0) begin errors++; $display("FAIL reset powered got %b exp 0", powered); end
        if (busy !== 0)    begin errors++; $display("FAIL reset busy got %b exp 0", busy); end
        if (fault !== 0)   begin errors++; $display("FAIL reset fault got %b exp 0", fault); end
        if (frail !== 0)   begin errors++; $display("FAIL reset fault_rail got %0d exp 0", frail); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        tick();
        checks += 2;
        if (en !== 5'd0) begin errors++; $display("FAIL post_reset en got %b exp 00000", en); end
        if (busy !== 0)  begin errors++; $display("FAIL post_reset busy got %b exp 0", busy); end
    endtask

    task automatic test_nominal_up;
        logic [4:0] e;
        plan(5);
        enable = 1'b1;
        for (int n = 1; n <= pwr_at + 2; n++) begin
            tick();
            e = exp_up(n, 5);
            checks += 4;
            if (en !== e) begin errors++; $display("FAIL nom_up en n=%0d got %b exp %b", n, en, e); end
            if (powered !== (n >= pwr_at)) begin errors++; $display("FAIL nom_up powered n=%0d got %b exp %b", n, powered, n >= pwr_at); end
            if (busy !== (n < pwr_at)) begin errors++; $display("FAIL nom_up busy n=%0d got %b exp %b", n, busy, n < pwr_at); end
            if (fault !== 1'b0) begin errors++; $display("FAIL nom_up fault n=%0d got %b exp 0", n, fault); end
        end
    endtask

    task automatic test_nominal_down;
        logic [4:0] e;
        int c;
        enable = 1'b0;
        for (int n = 1; n <= 28; n++) begin
            tick();
            c = (n - 1) / (S + 1) + 1;
            if (c > 5) c = 5;
            e = 5'h1f >> c;
            checks += 3;
            if (en !== e) begin errors++; $display("FAIL nom_down en n=%0d got %b exp %b", n, en, e); end
            if (busy !== (n < 5 * (S + 1) + 1)) begin errors++; $display("FAIL nom_down busy n=%0d got %b", n, busy); end
            if (powered !== 1'b0) begin errors++; $display("FAIL nom_down powered n=%0d got %b exp 0", n, powered); end
        end
    endtask

    task automatic test_timeout;
        int r = $urandom_range(0, 4);
        int lim;
        logic [4:0] e;
        plan(r);
        lim = rise[r] + T;
        enable = 1'b1;
        for (int n = 1; n <= lim + 1; n++) begin
            tick();
            e = exp_up(n, r);
            checks += 2;
            if (en !== e) begin errors++; $display("FAIL timeout en rail=%0d n=%0d got %b exp %b", r, n, en, e); end
            if (fault !== (n >= lim)) begin errors++; $display("FAIL timeout fault rail=%0d n=%0d got %b exp %b", r, n, fault, n >= lim); end
            if (n >= lim) begin
                checks++;
                if (frail !== r[2:0]) begin errors++; $display("FAIL timeout fault_rail got %0d exp %0d", frail, r); end
            end
        end
        enable = 1'b0;
        tick();
        checks += 3;
        if (fault !== 1'b0) begin errors++; $display("FAIL timeout clear fault got %b exp 0", fault); end
        if (en !== 5'd0) begin errors++; $display("FAIL timeout clear en got %b exp 00000", en); end
        if (frail !== r[2:0]) begin errors++; $display("FAIL timeout held fault_rail got %0d exp %0d", frail, r); end
        stuck = '0;
        enable = 1'b1;
        tick();
        checks += 2;
        if (en !== 5'b00001) begin errors++; $display("FAIL timeout restart en got %b exp 00001", en); end
        if (busy !== 1'b1) begin errors++; $display("FAIL timeout restart busy got %b exp 1", busy); end
        go_off();
    endtask

    task automatic test_pg_loss;
        logic [4:0] m;
        int lo;
        for (int rnd = 0; rnd < 3; rnd++) begin
            plan(5);
            enable = 1'b1;
            for (int n = 1; n <= pwr_at + 1; n++) tick();
            checks++;
            if (powered !== 1'b1) begin errors++; $display("FAIL pg_loss pre powered got %b exp 1", powered); end
            m = (rnd == 0) ? 5'b01010 : 5'($urandom_range(1, 31));
            lo = 0;
            for (int k = 4; k >= 0; k--) if (m[k]) lo = k;
            kill = m;
            if (rnd > 0) enable = 1'b0;
            tick();
            checks += 5;
            if (fault !== 1'b1) begin errors++; $display("FAIL pg_loss fault mask=%b got %b exp 1", m, fault); end
            if (frail !== lo[2:0]) begin errors++; $display("FAIL pg_loss fault_rail mask=%b got %0d exp %0d", m, frail, lo); end
            if (en !== 5'd0) begin errors++; $display("FAIL pg_loss en got %b exp 00000", en); end
            if (powered !== 1'b0) begin errors++; $display("FAIL pg_loss powered got %b exp 0", powered); end
            if (busy !== 1'b0) begin errors++; $display("FAIL pg_loss busy got %b exp 0", busy); end
            kill = '0;
            go_off();
        end
    endtask

    task automatic test_abort;
        int p;
        logic [4:0] e;
        plan(5);
        p = rise[2] + pg_dly[2];
        enable = 1'b1;
        for (int n = 1; n <= p + 2; n++) tick();
        checks++;
        if (en !== 5'b00111) begin errors++; $display("FAIL abort pre en got %b exp 00111", en); end
        enable = 1'b0;
        for (int n = p + 3; n <= p + 19; n++) begin
            tick();
            if (n < p + 18) e = 5'b00111 >> ((n - (p + 3)) / (S + 1) + 1);
            else e = (n == p + 19) ? 5'b00001 : 5'b00000;
            checks += 2;
            if (en !== e) begin errors++; $display("FAIL abort en n=%0d got %b exp %b", n - p, en, e); end
            if (busy !== (n != p + 18)) begin errors++; $display("FAIL abort busy n=%0d got %b exp %b", n - p, busy, n != p + 18); end
            if (n == p + 9) enable = 1'b1;
        end
        go_off();
    endtask

    task automatic test_async_reset;
        int p;
        plan(5);
        p = rise[1] + pg_dly[1];
        enable = 1'b1;
        for (int n = 1; n <= p + 2; n++) tick();
        #2 rst_n = 1'b0;
        #1;
        checks += 5;
        if (en !== 5'd0)   begin errors++; $display("FAIL async en got %b exp 00000", en); end
        if (powered !== 0) begin errors++; $display("FAIL async powered got %b exp 0", powered); end
        if (busy !== 0)    begin errors++; $display("FAIL async busy got %b exp 0", busy); end
        if (fault !== 0)   begin errors++; $display("FAIL async fault got %b exp 0", fault); end
        if (frail !== 0)   begin errors++; $display("FAIL async fault_rail got %0d exp 0", frail); end
        enable = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks += 2;
        if (en !== 5'd0) begin errors++; $display("FAIL async off en got %b exp 00000", en); end
        if (busy !== 0)  begin errors++; $display("FAIL async off busy got %b exp 0", busy); end
        stuck = 5'b00001;
        enable = 1'b1;
        for (int n = 1; n <= T + 1; n++) begin
            tick();
            checks += 2;
            if (en !== ((n < T + 1) ? 5'b00001 : 5'b00000)) begin errors++; $display("FAIL async cnt en n=%0d got %b", n, en); end
            if (fault !== (n >= T + 1)) begin errors++; $display("FAIL async cnt fault n=%0d got %b exp %b", n, fault, n >= T + 1); end
        end
        stuck = '0;
        go_off();
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 2; i++) begin
            test_nominal_up();
            test_nominal_down();
        end
    endtask

    initial begin
        for (int k = 0; k < 5; k++) begin
            pg_dly[k] = 1;
            age[k] = 0;
        end
        test_reset();
        test_nominal_up();
        test_nominal_down();
        test_timeout();
        test_pg_loss();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
